// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// key map, frame-result encoding and synchronizer depth.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_CHECK,
    ST_HELD,
    ST_RELEASE_CHECK
  } kp_state_t;

  localparam int SYNC_STAGES = 2;

  // Nibble i holds the code at column i/4, row i%4 (index 0 in the LSBs).
  localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } frame_result_t;

  localparam frame_result_t RESULT_NONE = '{valid: 1'b0, code: 4'h0};

  function automatic logic [3:0] key_lookup(input logic [3:0] idx);
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction

  // Exactly one pressed bit yields that key; zero or several yield NONE.
  function automatic frame_result_t encode_frame(input logic [15:0] pressed);
    frame_result_t res;
    int            n;
    res = RESULT_NONE;
    n   = 0;
    for (int i = 0; i < 16; i++) begin
      if (pressed[i]) begin
        n++;
        res.code = key_lookup(4'(i));
      end
    end
    if (n == 1) res.valid = 1'b1;
    else        res = RESULT_NONE;
    return res;
  endfunction

endpackage

// File: rtl/keypad_matrix_scan.sv
// Column sequencer, row synchronizer and per-frame sample/encode stage.
// frame_done and the result are combinational during the col3 sample cycle.
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS = 100_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       frame_done,
  output logic       result_valid,
  output logic [3:0] result_code
);

  localparam int TICK_W = $clog2(SCAN_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);

  logic [TICK_W-1:0] r_tick;
  logic [1:0]        r_col_idx;
  logic [3:0]        r_col;
  logic [3:0]        r_sync [SYNC_STAGES];
  logic [15:0]       r_frame;
  logic [15:0]       w_frame_next;
  logic              w_sample;
  logic [3:0]        w_row_sync;
  frame_result_t     w_result;

  // Idle rows are pulled up, so the synchronizer resets to all-ones.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clock) begin
          if (reset) r_sync[gi] <= 4'hF;
          else       r_sync[gi] <= row;
        end
      end else begin : g_next
        always_ff @(posedge clock) begin
          if (reset) r_sync[gi] <= 4'hF;
          else       r_sync[gi] <= r_sync[gi-1];
        end
      end
    end
  endgenerate

  assign w_row_sync = r_sync[SYNC_STAGES-1];
  assign w_sample   = (r_tick == TICK_LAST);

  // Column 0 sits on the MSB of the drive bus, so the low bit rotates right.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tick    <= '0;
      r_col_idx <= 2'd0;
      r_col     <= 4'b0111;
      r_frame   <= '0;
    end else if (w_sample) begin
      r_tick    <= '0;
      r_col_idx <= r_col_idx + 2'd1;
      r_col     <= {r_col[0], r_col[3:1]};
      r_frame   <= w_frame_next;
    end else begin
      r_tick    <= r_tick + TICK_W'(1);
    end
  end

  always_comb begin
    w_frame_next = r_frame;
    w_frame_next[{r_col_idx, 2'b00} +: 4] = ~w_row_sync;
  end

  assign w_result     = encode_frame(w_frame_next);
  assign frame_done   = w_sample && (r_col_idx == 2'd3);
  assign result_valid = w_result.valid;
  assign result_code  = w_result.code;
  assign col          = r_col;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad reader: matrix scanner plus frame-level debounce FSM.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key is held.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 100_000,
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_FRAMES = 250
`endif
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

  logic             w_frame_done;
  logic             w_result_valid;
  logic [3:0]       w_result_code;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_inc;

  kp_state_t        r_state;
  logic [3:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  logic [REP_W-1:0] r_rep;
  logic [REP_W-1:0] w_rep_inc;
  assign w_rep_inc = r_rep + REP_W'(1);
`endif

  keypad_matrix_scan #(
    .SCAN_TICKS(SCAN_TICKS)
  ) u_scan (
    .clock       (clock),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .frame_done  (w_frame_done),
    .result_valid(w_result_valid),
    .result_code (w_result_code)
  );

  assign w_match   = w_result_valid && (w_result_code == r_cand);
  assign w_cnt_inc = r_cnt + CNT_ONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cand      <= 4'h0;
      r_cnt       <= '0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep       <= '0;
`endif
    end else begin
      r_key_valid <= 1'b0;
      if (w_frame_done) begin
        case (r_state)
          ST_IDLE: begin
            if (w_result_valid) begin
              r_state <= ST_PRESS_CHECK;
              r_cand  <= w_result_code;
              r_cnt   <= CNT_ONE;
            end
          end
          ST_PRESS_CHECK: begin
            if (w_match) begin
              if (w_cnt_inc == CNT_TARGET) begin
                r_state     <= ST_HELD;
                r_key_code  <= r_cand;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_cnt       <= '0;
`ifdef KEYPAD_REPEAT_EN
                r_rep       <= '0;
`endif
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else if (w_result_valid) begin
              r_cand <= w_result_code;
              r_cnt  <= CNT_ONE;
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          end
          ST_HELD: begin
            if (!w_match) begin
              r_state <= ST_RELEASE_CHECK;
              r_cnt   <= CNT_ONE;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (w_rep_inc == REP_W'(REPEAT_FRAMES)) begin
              r_key_valid <= 1'b1;
              r_rep       <= '0;
            end else begin
              r_rep <= w_rep_inc;
            end
`endif
          end
          ST_RELEASE_CHECK: begin
            // A bounce back to the same key resumes HELD silently.
            if (w_match) begin
              r_state <= ST_HELD;
              r_cnt   <= '0;
            end else if (w_cnt_inc == CNT_TARGET) begin
              r_state    <= ST_IDLE;
              r_key_held <= 1'b0;
              r_cnt      <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_TICKS=4, DEBOUNCE_SCANS=3 (16-cycle frames).
// Build with KEYPAD_REPEAT_EN defined to exercise auto-repeat (REPEAT_FRAMES=2).
module tb_keypad_scan;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] mask = 16'h0000;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [15:0] K1 = 16'h0001;  // col0 row0
  localparam logic [15:0] K2 = 16'h0010;  // col1 row0
  localparam logic [15:0] K5 = 16'h0020;  // col1 row1
  localparam logic [15:0] K9 = 16'h0400;  // col2 row2
  localparam logic [15:0] KA = 16'h1000;  // col3 row0
  localparam logic [15:0] KC = 16'h4000;  // col3 row2

  keypad_scan #(
    .SCAN_TICKS    (4),
    .DEBOUNCE_SCANS(3)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_FRAMES(2)
`endif
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clock = ~clock;

  // Keypad model: the active column pulls the rows of its pressed keys low.
  always_comb begin
    row = 4'hF;
    case (col)
      4'b0111: row = ~mask[3:0];
      4'b1011: row = ~mask[7:4];
      4'b1101: row = ~mask[11:8];
      4'b1110: row = ~mask[15:12];
      default: row = 4'hF;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Leaves the bench at the negedge of cycle 1 after reset release (tick 1 of col0).
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    step();
    check_eq("rst col", col, 4'b0111);
    check_eq("rst valid", key_valid, 0);
    step();
    reset = 1'b0;
    check_eq("rst code", key_code, 0);
    check_eq("rst held", key_held, 0);
    step();
  endtask

  task automatic run_frame(input string tag, input logic [15:0] m, input int exp_pulses,
                           input logic [3:0] exp_code, input logic exp_held);
    int pulses;
    pulses = 0;
    mask = m;
    repeat (16) begin
      step();
      if (key_valid) pulses++;
    end
    check_eq({tag, " pulses"}, pulses, exp_pulses);
    check_eq({tag, " code"}, key_code, exp_code);
    check_eq({tag, " held"}, key_held, exp_held);
    $display("[TB] frame %s mask=%h pulses=%0d code=%h held=%b", tag, m, pulses, key_code, key_held);
  endtask

  int rep_exp [9];

  initial begin
`ifdef KEYPAD_REPEAT_EN
    rep_exp = '{0, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    rep_exp = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
`endif

    // Idle scan and column walk
    do_reset();
    repeat (3) step();
    check_eq("col1", col, 4'b1011);
    repeat (4) step();
    check_eq("col2", col, 4'b1101);
    repeat (4) step();
    check_eq("col3", col, 4'b1110);
    repeat (4) step();
    check_eq("col0 wrap", col, 4'b0111);
    step();
    run_frame("idle0", 16'h0000, 0, 4'h0, 1'b0);
    run_frame("idle1", 16'h0000, 0, 4'h0, 1'b0);

    // Key 5 held steady
    do_reset();
    run_frame("k5 f1", K5, 0, 4'h0, 1'b0);
    run_frame("k5 f2", K5, 0, 4'h0, 1'b0);
    run_frame("k5 f3", K5, 1, 4'h5, 1'b1);
    run_frame("k5 f4", K5, 0, 4'h5, 1'b1);

    // Key 5 on alternate frames only
    do_reset();
    for (int i = 0; i < 6; i++)
      run_frame($sformatf("alt%0d", i), (i % 2 == 0) ? K5 : 16'h0000, 0, 4'h0, 1'b0);

    // Multi-press ignored, then key 9 with a short and a full release
    do_reset();
    for (int i = 0; i < 5; i++)
      run_frame($sformatf("multi%0d", i), K1 | K2, 0, 4'h0, 1'b0);
    run_frame("k9 f1", K9, 0, 4'h0, 1'b0);
    run_frame("k9 f2", K9, 0, 4'h0, 1'b0);
    run_frame("k9 f3", K9, 1, 4'h9, 1'b1);
    run_frame("k9 rel1", 16'h0000, 0, 4'h9, 1'b1);
    run_frame("k9 rel2", 16'h0000, 0, 4'h9, 1'b1);
    run_frame("k9 again", K9, 0, 4'h9, 1'b1);
    run_frame("k9 off1", 16'h0000, 0, 4'h9, 1'b1);
    run_frame("k9 off2", 16'h0000, 0, 4'h9, 1'b1);
    run_frame("k9 off3", 16'h0000, 0, 4'h9, 1'b0);

    // Reset during the second matching frame of key A
    do_reset();
    run_frame("kA f1", KA, 0, 4'h0, 1'b0);
    repeat (8) step();
    check_eq("kA mid valid", key_valid, 0);
    do_reset();
    run_frame("kA r1", KA, 0, 4'h0, 1'b0);
    run_frame("kA r2", KA, 0, 4'h0, 1'b0);
    run_frame("kA r3", KA, 1, 4'hA, 1'b1);

    // Key C held for nine frames (repeat pulses only when enabled)
    do_reset();
    for (int i = 0; i < 9; i++)
      run_frame($sformatf("kC f%0d", i + 1), KC, rep_exp[i], (i >= 2) ? 4'hC : 4'h0, (i >= 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
